// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, event layout and FSM state type for ps2_keyq
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int EV_W   = 10;
  localparam int EV_REL = 9;
  localparam int EV_EXT = 8;

  // bit1 = break prefix seen, bit0 = extended prefix seen
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXT    = 2'b01,
    ST_BRK    = 2'b10,
    ST_EXTBRK = 2'b11
  } ps2_state_e;

endpackage

// File: rtl/ps2_keyq_if.sv
// rtl/ps2_keyq_if.sv - receiver byte stream and CPU-side event queue signals
interface ps2_keyq_if #(parameter int AW = 3) ();
  logic [7:0]  code;
  logic        parity;
  logic        rdy;
  logic        error;
  logic        ev_rd;
  logic        ovf_clr;
  logic [9:0]  ev_data;
  logic        ev_valid;
  logic [AW:0] ev_count;
  logic        overflow;
  logic        perr;

  modport master (
    output code, parity, rdy, error, ev_rd, ovf_clr,
    input  ev_data, ev_valid, ev_count, overflow, perr
  );

  modport slave (
    input  code, parity, rdy, error, ev_rd, ovf_clr,
    output ev_data, ev_valid, ev_count, overflow, perr
  );
endinterface

// File: rtl/ps2_keyq_fifo.sv
// rtl/ps2_keyq_fifo.sv - first-word-fall-through event FIFO with occupancy count
module ps2_keyq_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keyq.sv
// rtl/ps2_keyq.sv - folds PS/2 E0/F0 prefixes into key events and queues them
// Optional typematic filter: PS2_KEYQ_AUTOREPEAT_FILTER_EN
module ps2_keyq
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         reset,
  ps2_keyq_if.slave    bus
);

  ps2_state_e      state, state_n;
  logic            error_d;
  logic            err_rise;
  logic            par_ok;
  logic            ev_req;
  logic [EV_W-1:0] ev_bits;
  logic            perr_set;
  logic            filt;
  logic            push;
  logic            full;
  logic            empty;
  logic            ovf_set;
  logic            overflow;
  logic            perr;

  assign err_rise = bus.error & ~error_d;
  assign par_ok   = ^{bus.code, bus.parity};

  // A prefix only ORs its flag into the state, so prefix order does not matter.
  always_comb begin
    state_n  = state;
    ev_req   = 1'b0;
    ev_bits  = '0;
    perr_set = 1'b0;
    if (err_rise) begin
      state_n = ST_IDLE;
    end else if (bus.rdy) begin
      if (!par_ok) begin
        perr_set = 1'b1;
        state_n  = ST_IDLE;
      end else if (bus.code == PS2_PFX_EXT) begin
        state_n = ps2_state_e'(state | ST_EXT);
      end else if (bus.code == PS2_PFX_BRK) begin
        state_n = ps2_state_e'(state | ST_BRK);
      end else begin
        ev_req          = 1'b1;
        ev_bits[7:0]    = bus.code;
        ev_bits[EV_REL] = state[1];
        ev_bits[EV_EXT] = state[0];
        state_n         = ST_IDLE;
      end
    end
  end

`ifdef PS2_KEYQ_AUTOREPEAT_FILTER_EN
  logic [8:0] last_make;
  logic       last_vld;

  assign filt = ev_req & ~ev_bits[EV_REL] & last_vld & (ev_bits[8:0] == last_make);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_make <= '0;
      last_vld  <= 1'b0;
    end else if (ev_req && !filt) begin
      if (!ev_bits[EV_REL]) begin
        last_make <= ev_bits[8:0];
        last_vld  <= 1'b1;
      end else if (ev_bits[8:0] == last_make) begin
        last_vld  <= 1'b0;
      end
    end
  end
`else
  assign filt = 1'b0;
`endif

  assign push    = ev_req & ~filt;
  assign ovf_set = push & full & ~bus.ev_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      error_d  <= 1'b0;
      overflow <= 1'b0;
      perr     <= 1'b0;
    end else begin
      state   <= state_n;
      error_d <= bus.error;
      if (ovf_set)          overflow <= 1'b1;
      else if (bus.ovf_clr) overflow <= 1'b0;
      if (perr_set)         perr <= 1'b1;
      else if (bus.ovf_clr) perr <= 1'b0;
    end
  end

  ps2_keyq_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EV_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (ev_bits),
    .pop       (bus.ev_rd),
    .rd_data   (bus.ev_data),
    .empty     (empty),
    .full      (full),
    .count     (bus.ev_count)
  );

  assign bus.ev_valid = ~empty;
  assign bus.overflow = overflow;
  assign bus.perr     = perr;

endmodule

// File: tb/tb_ps2_keyq.sv
// tb/tb_ps2_keyq.sv - table-driven and scoreboard checks for ps2_keyq
module tb_ps2_keyq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_keyq_if #(.AW(3)) bus ();

  ps2_keyq #(.DEPTH(8), .AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic       push;
    logic [9:0] ev;
    logic       perr;
  } vec_t;

  vec_t        vecs [13];
  logic [9:0]  q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic bad);
    bus.code   = c;
    bus.parity = ~(^c) ^ bad;
    bus.rdy    = 1'b1;
    tick();
    bus.rdy    = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [9:0] e;
    e = q.pop_front();
    check({name, "_valid"}, 32'(bus.ev_valid), 32'd1);
    check({name, "_data"}, 32'(bus.ev_data), 32'(e));
    bus.ev_rd = 1'b1;
    tick();
    bus.ev_rd = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      pop_check(name);
      guard++;
    end
    check({name, "_empty_valid"}, 32'(bus.ev_valid), 32'd0);
    check({name, "_empty_count"}, 32'(bus.ev_count), 32'd0);
  endtask

  initial begin
    bus.code    = '0;
    bus.parity  = 1'b0;
    bus.rdy     = 1'b0;
    bus.error   = 1'b0;
    bus.ev_rd   = 1'b0;
    bus.ovf_clr = 1'b0;
    reset       = 1'b1;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 10'h21C, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, 10'h175, 1'b0};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[7]  = '{8'h75, 1'b0, 1'b1, 10'h375, 1'b0};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[10] = '{8'h6B, 1'b0, 1'b1, 10'h36B, 1'b0};
    vecs[11] = '{8'h1C, 1'b1, 1'b0, 10'h000, 1'b1};
    vecs[12] = '{8'h2A, 1'b0, 1'b1, 10'h02A, 1'b1};

    tick();
    tick();
    check("rst_ev_data", 32'(bus.ev_data), 32'd0);
    check("rst_ev_valid", 32'(bus.ev_valid), 32'd0);
    check("rst_ev_count", 32'(bus.ev_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_perr", 32'(bus.perr), 32'd0);
    reset = 1'b0;
    tick();

    // first event must be visible the cycle after its rdy
    check("lat_valid_before", 32'(bus.ev_valid), 32'd0);
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].code, vecs[i].bad);
      if (vecs[i].push) q.push_back(vecs[i].ev);
      if (i == 0) begin
        check("lat_valid", 32'(bus.ev_valid), 32'd1);
        check("lat_data", 32'(bus.ev_data), 32'h01C);
      end
      check($sformatf("vec%0d_count", i), 32'(bus.ev_count), 32'(q.size()));
      check($sformatf("vec%0d_perr", i), 32'(bus.perr), 32'(vecs[i].perr));
    end
    drain("vec_drain");
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("perr_clr", 32'(bus.perr), 32'd0);

    // overflow: nine makes, no pops
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), 1'b0);
      if (i <= 8) q.push_back(10'(i));
    end
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.ev_count), 32'd8);
    check("ovf_head", 32'(bus.ev_data), 32'h001);
    drain("ovf_drain");
    bus.ev_rd = 1'b1;
    tick();
    bus.ev_rd = 1'b0;
    check("underflow_count", 32'(bus.ev_count), 32'd0);
    check("underflow_valid", 32'(bus.ev_valid), 32'd0);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      send(8'h41 + 8'(i), 1'b0);
      q.push_back(10'h041 + 10'(i));
    end
    check("full_count", 32'(bus.ev_count), 32'd8);
    check("full_pp_head", 32'(bus.ev_data), 32'(q.pop_front()));
    bus.code   = 8'h33;
    bus.parity = ~(^8'h33);
    bus.rdy    = 1'b1;
    bus.ev_rd  = 1'b1;
    q.push_back(10'h033);
    tick();
    bus.rdy    = 1'b0;
    bus.ev_rd  = 1'b0;
    check("full_pp_count", 32'(bus.ev_count), 32'd8);
    check("full_pp_ovf", 32'(bus.overflow), 32'd0);
    drain("full_pp_drain");

    // receiver error edge aborts the extended prefix
    send(8'hE0, 1'b0);
    bus.error = 1'b1;
    tick();
    send(8'h74, 1'b0);
    q.push_back(10'h074);
    check("err_count", 32'(bus.ev_count), 32'd1);
    bus.error = 1'b0;
    tick();
    bus.error = 1'b1;
    send(8'h55, 1'b0);
    check("err_rise_nopush", 32'(bus.ev_count), 32'd1);
    drain("err_drain");
    bus.error = 1'b0;
    tick();

    // typematic repeats
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    q.push_back(10'h01C);
`ifndef PS2_KEYQ_AUTOREPEAT_FILTER_EN
    q.push_back(10'h01C);
    q.push_back(10'h01C);
`endif
    q.push_back(10'h21C);
    check("rep_count", 32'(bus.ev_count), 32'(q.size()));
    check("rep_ovf", 32'(bus.overflow), 32'd0);
    drain("rep_drain");

    // reset after a prefix loses the queue and the prefix
    send(8'h22, 1'b0);
    send(8'hE0, 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_count", 32'(bus.ev_count), 32'd0);
    check("midrst_valid", 32'(bus.ev_valid), 32'd0);
    q.delete();
    reset = 1'b0;
    tick();
    send(8'h75, 1'b0);
    q.push_back(10'h075);
    drain("midrst_drain");

    // parity error coinciding with clear: set wins
    bus.ovf_clr = 1'b1;
    send(8'h1C, 1'b1);
    bus.ovf_clr = 1'b0;
    check("perr_set_wins", 32'(bus.perr), 32'd1);
    check("perr_no_event", 32'(bus.ev_count), 32'd0);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("perr_clr2", 32'(bus.perr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
